// File: rtl/tuart_rx_cmd.sv
// UART receiver and SUMP command assembler: samples the synchronised rx line, checks framing and parity,
// and packs accepted words into short (opcode only) or long commands.
module tuart_rx_cmd #(
  parameter int DATA_BITS       = 8,
  parameter int CMD_WIDTH_WORDS = 5,
  parameter int DIV_WIDTH       = 16,
  parameter int PARITY_EN       = 0,
  parameter int PARITY_ODD      = 0,
  parameter int STOP_BITS       = 1,
  parameter int TIMEOUT_CYCLES  = 100000
) (
  input  logic                                   clk_i,
  input  logic                                   rst_in,
  input  logic                                   rx_sync_i,
  input  logic [DIV_WIDTH-1:0]                   div_i,
  output logic [DATA_BITS*CMD_WIDTH_WORDS-1:0]   data_o,
  output logic                                   stb_o,
  output logic                                   err_frame_o,
  output logic                                   err_parity_o,
  output logic                                   err_timeout_o,
  output logic                                   busy_o
);

  localparam int CMD_W = DATA_BITS * CMD_WIDTH_WORDS;
  localparam int WC_W  = $clog2(CMD_WIDTH_WORDS + 1);
  localparam int BC_W  = $clog2(DATA_BITS + 1);
  localparam int IC_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  state_t                 r_state, w_state_nxt;
  logic [DIV_WIDTH-1:0]   r_div, w_div_nxt, w_div_eff;
  logic [DIV_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [BC_W-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [1:0]             r_stop_cnt, w_stop_cnt_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_par_bad, w_par_bad_nxt;
  logic [WC_W-1:0]        r_word_cnt, w_word_cnt_nxt;
  logic [CMD_W-1:0]       r_asm, w_asm_nxt, w_slot;
  logic [IC_W-1:0]        r_idle_cnt, w_idle_cnt_nxt;
  logic [CMD_W-1:0]       r_data;
  logic                   r_stb, r_err_frame, r_err_parity, r_err_timeout, r_busy;
  logic                   w_accept, w_ferr, w_perr, w_tout, w_complete, w_busy_nxt;
  logic                   w_bit_smp, w_start_smp;

  assign data_o        = r_data;
  assign stb_o         = r_stb;
  assign err_frame_o   = r_err_frame;
  assign err_parity_o  = r_err_parity;
  assign err_timeout_o = r_err_timeout;
  assign busy_o        = r_busy;

  // Divisor clamp and sample-point decode; r_div is only meaningful outside IDLE
  always_comb begin
    w_div_eff   = (div_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : div_i;
    w_start_smp = (r_cnt == ((r_div >> 1) - DIV_WIDTH'(1)));
    w_bit_smp   = (r_cnt == (r_div - DIV_WIDTH'(1)));
  end

  // Frame state register
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Frame FSM: next state, bit sampling and per-byte verdict
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + DIV_WIDTH'(1);
    w_div_nxt      = r_div;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_shift_nxt    = r_shift;
    w_par_bad_nxt  = r_par_bad;
    w_accept       = 1'b0;
    w_ferr         = 1'b0;
    w_perr         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (!rx_sync_i) begin
          w_state_nxt    = S_START;
          w_div_nxt      = w_div_eff;
          w_bit_cnt_nxt  = '0;
          w_stop_cnt_nxt = 2'd0;
          w_par_bad_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_start_smp) begin
          w_cnt_nxt   = '0;
          w_state_nxt = rx_sync_i ? S_IDLE : S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_bit_smp) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {rx_sync_i, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == BC_W'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_bit_smp) begin
          w_cnt_nxt     = '0;
          w_par_bad_nxt = parity_of(r_shift) ^ rx_sync_i ^ (PARITY_ODD != 0);
          w_state_nxt   = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_bit_smp) begin
          w_cnt_nxt = '0;
          if (!rx_sync_i) begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end else if (r_stop_cnt == 2'(STOP_BITS - 1)) begin
            w_state_nxt = S_IDLE;
            w_perr      = r_par_bad;
            w_accept    = !r_par_bad;
          end else begin
            w_stop_cnt_nxt = r_stop_cnt + 2'd1;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      S_BREAK: begin
        // A held-low line stays here so it reports only one framing error
        w_cnt_nxt   = '0;
        w_state_nxt = rx_sync_i ? S_IDLE : S_BREAK;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Command assembly, completion detect and inter-byte timeout
  always_comb begin
    w_slot         = r_asm;
    w_asm_nxt      = r_asm;
    w_word_cnt_nxt = r_word_cnt;
    w_idle_cnt_nxt = '0;
    w_complete     = 1'b0;
    w_tout         = 1'b0;
    for (int k = 0; k < CMD_WIDTH_WORDS; k++) begin
      if (WC_W'(k) == r_word_cnt) begin
        w_slot[k*DATA_BITS +: DATA_BITS] = r_shift;
      end else begin
        w_slot[k*DATA_BITS +: DATA_BITS] = r_asm[k*DATA_BITS +: DATA_BITS];
      end
    end
    if ((TIMEOUT_CYCLES > 0) && (r_state == S_IDLE) && (r_word_cnt != '0)) begin
      if (r_idle_cnt == IC_W'(TIMEOUT_CYCLES - 1)) begin
        w_tout = 1'b1;
      end else begin
        w_idle_cnt_nxt = r_idle_cnt + IC_W'(1);
      end
    end else begin
      w_idle_cnt_nxt = '0;
    end
    if (w_accept) begin
      if (((r_word_cnt == '0) && !r_shift[DATA_BITS-1]) ||
          (r_word_cnt == WC_W'(CMD_WIDTH_WORDS - 1))) begin
        w_complete     = 1'b1;
        w_asm_nxt      = '0;
        w_word_cnt_nxt = '0;
      end else begin
        w_asm_nxt      = w_slot;
        w_word_cnt_nxt = r_word_cnt + WC_W'(1);
      end
    end else if (w_ferr || w_perr || w_tout) begin
      w_asm_nxt      = '0;
      w_word_cnt_nxt = '0;
    end else begin
      w_asm_nxt = r_asm;
    end
    w_busy_nxt = (w_state_nxt != S_IDLE) || (w_word_cnt_nxt != '0);
  end

  // Datapath registers and registered output pulses
  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_div         <= '0;
      r_cnt         <= '0;
      r_bit_cnt     <= '0;
      r_stop_cnt    <= 2'd0;
      r_shift       <= '0;
      r_par_bad     <= 1'b0;
      r_word_cnt    <= '0;
      r_asm         <= '0;
      r_idle_cnt    <= '0;
      r_data        <= '0;
      r_stb         <= 1'b0;
      r_err_frame   <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_cnt         <= w_cnt_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_stop_cnt    <= w_stop_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_par_bad     <= w_par_bad_nxt;
      r_word_cnt    <= w_word_cnt_nxt;
      r_asm         <= w_asm_nxt;
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_data        <= w_complete ? w_slot : r_data;
      r_stb         <= w_complete;
      r_err_frame   <= w_ferr;
      r_err_parity  <= w_perr;
      r_err_timeout <= w_tout;
      r_busy        <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_tuart_rx_cmd.sv
// Directed bench: instance a is 8N1 with a 200-clock timeout, instance b is 8E1.
module tb_tuart_rx_cmd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_a, rx_b;
  logic [15:0] div_a, div_b;
  logic [39:0] data_a, data_b;
  logic        stb_a_o, fe_a_o, pe_a_o, to_a_o, busy_a;
  logic        stb_b_o, fe_b_o, pe_b_o, to_b_o, busy_b;

  int n_chk  = 0;
  int n_fail = 0;
  int stb_a = 0, fe_a = 0, pe_a = 0, to_a = 0;
  int stb_b = 0, fe_b = 0, pe_b = 0;
  int b_stb, b_fe, b_pe, b_to;

  always #5 clk = ~clk;

  tuart_rx_cmd #(.TIMEOUT_CYCLES(200)) u_dut_a (
    .clk_i(clk), .rst_in(rst_n), .rx_sync_i(rx_a), .div_i(div_a),
    .data_o(data_a), .stb_o(stb_a_o), .err_frame_o(fe_a_o), .err_parity_o(pe_a_o),
    .err_timeout_o(to_a_o), .busy_o(busy_a)
  );

  tuart_rx_cmd #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
    .clk_i(clk), .rst_in(rst_n), .rx_sync_i(rx_b), .div_i(div_b),
    .data_o(data_b), .stb_o(stb_b_o), .err_frame_o(fe_b_o), .err_parity_o(pe_b_o),
    .err_timeout_o(to_b_o), .busy_o(busy_b)
  );

  // Count every clock cycle each pulse is high, so stretched pulses show up as extra counts
  always @(posedge clk) begin
    if (stb_a_o) stb_a <= stb_a + 1;
    if (fe_a_o)  fe_a  <= fe_a + 1;
    if (pe_a_o)  pe_a  <= pe_a + 1;
    if (to_a_o)  to_a  <= to_a + 1;
    if (stb_b_o) stb_b <= stb_b + 1;
    if (fe_b_o)  fe_b  <= fe_b + 1;
    if (pe_b_o)  pe_b  <= pe_b + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic b, input int n);
    if (which == 0) rx_a = b;
    else            rx_b = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input int which, input logic [7:0] v, input int div,
                      input bit use_par, input logic par, input logic stop);
    @(negedge clk);
    drive(which, 1'b0, div);
    for (int i = 0; i < 8; i++) drive(which, v[i], div);
    if (use_par) drive(which, par, div);
    drive(which, stop, div);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_stb = stb_a; b_fe = fe_a; b_pe = pe_a; b_to = to_a;
  endtask

  initial begin
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; div_a = 16'd10; div_b = 16'd10;
    idle(3);
    check("rst_data", 64'(data_a), 64'h0);
    check("rst_pulses", 64'({stb_a_o, fe_a_o, pe_a_o, to_a_o}), 64'h0);
    check("rst_busy", 64'(busy_a), 64'h0);
    rst_n = 1'b1;
    idle(4);

    // 1: short command
    snap();
    send(0, 8'h11, 10, 1'b0, 1'b0, 1'b1); idle(5);
    check("t1_stb", 64'(stb_a - b_stb), 64'd1);
    check("t1_data", 64'(data_a), 64'h11);
    check("t1_err", 64'((fe_a - b_fe) + (pe_a - b_pe) + (to_a - b_to)), 64'd0);
    check("t1_busy", 64'(busy_a), 64'h0);

    // 2: long command
    snap();
    send(0, 8'h80, 10, 1'b0, 1'b0, 1'b1); idle(5);
    check("t2_busy_partial", 64'(busy_a), 64'h1);
    check("t2_no_stb_yet", 64'(stb_a - b_stb), 64'd0);
    send(0, 8'h01, 10, 1'b0, 1'b0, 1'b1);
    send(0, 8'h02, 10, 1'b0, 1'b0, 1'b1);
    send(0, 8'h03, 10, 1'b0, 1'b0, 1'b1);
    send(0, 8'h04, 10, 1'b0, 1'b0, 1'b1); idle(5);
    check("t2_stb", 64'(stb_a - b_stb), 64'd1);
    check("t2_data", 64'(data_a), 64'h04_03_02_01_80);

    // 3: false start
    snap();
    rx_a = 1'b0; idle(3); rx_a = 1'b1; idle(20);
    check("t3_busy", 64'(busy_a), 64'h0);
    check("t3_quiet", 64'((stb_a - b_stb) + (fe_a - b_fe)), 64'd0);
    send(0, 8'h11, 10, 1'b0, 1'b0, 1'b1); idle(5);
    check("t3_stb", 64'(stb_a - b_stb), 64'd1);
    check("t3_data", 64'(data_a), 64'h11);

    // 4: framing error and held-low line
    snap();
    send(0, 8'h80, 10, 1'b0, 1'b0, 1'b1);
    send(0, 8'h55, 10, 1'b0, 1'b0, 1'b0);
    idle(50);
    check("t4_ferr", 64'(fe_a - b_fe), 64'd1);
    check("t4_no_stb", 64'(stb_a - b_stb), 64'd0);
    check("t4_busy_break", 64'(busy_a), 64'h1);
    rx_a = 1'b1; idle(20);
    check("t4_ferr_once", 64'(fe_a - b_fe), 64'd1);
    check("t4_busy_idle", 64'(busy_a), 64'h0);
    send(0, 8'h11, 10, 1'b0, 1'b0, 1'b1); idle(5);
    check("t4_stb", 64'(stb_a - b_stb), 64'd1);
    check("t4_data", 64'(data_a), 64'h11);

    // 5: even parity on instance b
    send(1, 8'h03, 10, 1'b1, 1'b1, 1'b1); idle(5);
    check("t5_perr", 64'(pe_b), 64'd1);
    check("t5_no_stb", 64'(stb_b), 64'd0);
    send(1, 8'h03, 10, 1'b1, 1'b0, 1'b1); idle(5);
    check("t5_stb", 64'(stb_b), 64'd1);
    check("t5_data", 64'(data_b), 64'h03);
    check("t5_perr_once", 64'(pe_b + fe_b), 64'd1);

    // 6: inter-byte timeout
    snap();
    send(0, 8'h80, 10, 1'b0, 1'b0, 1'b1);
    send(0, 8'h01, 10, 1'b0, 1'b0, 1'b1);
    idle(150);
    check("t6_no_tout_early", 64'(to_a - b_to), 64'd0);
    check("t6_busy_pending", 64'(busy_a), 64'h1);
    idle(100);
    check("t6_tout", 64'(to_a - b_to), 64'd1);
    check("t6_busy_dropped", 64'(busy_a), 64'h0);
    send(0, 8'h11, 10, 1'b0, 1'b0, 1'b1); idle(5);
    check("t6_stb", 64'(stb_a - b_stb), 64'd1);
    check("t6_data", 64'(data_a), 64'h11);

    // Reset in the middle of the second word of a long command
    snap();
    send(0, 8'h80, 10, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 10);
    drive(0, 1'b1, 30);
    rst_n = 1'b0; idle(2);
    check("rst_mid_data", 64'(data_a), 64'h0);
    check("rst_mid_busy", 64'(busy_a), 64'h0);
    rx_a = 1'b1; rst_n = 1'b1; idle(30);
    check("rst_mid_quiet", 64'((stb_a - b_stb) + (fe_a - b_fe) + (to_a - b_to)), 64'd0);
    send(0, 8'h11, 10, 1'b0, 1'b0, 1'b1); idle(5);
    check("rst_mid_stb", 64'(stb_a - b_stb), 64'd1);
    check("rst_mid_data2", 64'(data_a), 64'h11);

    // Slower and clamped divisors
    snap();
    div_a = 16'd20;
    send(0, 8'h3c, 20, 1'b0, 1'b0, 1'b1); idle(10);
    check("div20_data", 64'(data_a), 64'h3c);
    send(0, 8'h11, 20, 1'b0, 1'b0, 1'b1); idle(10);
    check("div20_stb", 64'(stb_a - b_stb), 64'd2);
    check("div20_data2", 64'(data_a), 64'h11);
    div_a = 16'd1;
    send(0, 8'h5a, 2, 1'b0, 1'b0, 1'b1); idle(10);
    check("div1_data", 64'(data_a), 64'h5a);
    check("div1_stb", 64'(stb_a - b_stb), 64'd3);
    check("div_err", 64'((fe_a - b_fe) + (pe_a - b_pe)), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
